// File: rtl/scan_sequencer_if.sv
// Bundle of the scan sequencer's control, mux and sample-stream signals.
// master = sequencer side, slave = environment (mux + consumer + software) side.
interface scan_sequencer_if #(
  parameter int NCH = 6,
  parameter int W   = 4
);
  logic           start;
  logic [NCH-1:0] ch_mask;
  logic [2:0]     sel;
  logic [W-1:0]   mux_out;
  logic           out_valid;
  logic           out_ready;
  logic [2:0]     out_ch;
  logic [W-1:0]   out_data;
  logic           busy;
  logic           done;

  modport master (
    input  start, ch_mask, mux_out, out_ready,
    output sel, out_valid, out_ch, out_data, busy, done
  );

  modport slave (
    output start, ch_mask, mux_out, out_ready,
    input  sel, out_valid, out_ch, out_data, busy, done
  );
endinterface

// File: rtl/scan_sequencer.sv
// Walks a mux select through the enabled channels, emitting one (channel, data) beat each.
// Optional macro SCAN_SEQ_ZERO_SKIP_EN: channels that sample zero are dropped without a beat.
module scan_sequencer #(
  parameter int NCH = 6,
  parameter int W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  scan_sequencer_if.master bus
);

`ifdef SCAN_SEQ_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CAPTURE, OUT, DONE} state_t;

  state_t         state;
  logic [NCH-1:0] pend;
  logic [2:0]     cur;
  logic [NCH-1:0] rest;

  function automatic logic [2:0] lowest(input logic [NCH-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Channels still owed once the current one is retired.
  assign rest = pend & ~(NCH'(1) << cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pend          <= '0;
      cur           <= '0;
      bus.sel       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_data  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            pend     <= bus.ch_mask;
            cur      <= lowest(bus.ch_mask);
            bus.busy <= 1'b1;
            if (bus.ch_mask != '0) begin
              state   <= CAPTURE;
              bus.sel <= lowest(bus.ch_mask);
            end else begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (ZERO_SKIP && bus.mux_out == '0) begin
            pend <= rest;
            if (rest != '0) begin
              cur     <= lowest(rest);
              bus.sel <= lowest(rest);
            end else begin
              state    <= DONE;
              bus.sel  <= '0;
              bus.done <= 1'b1;
            end
          end else begin
            bus.out_data  <= bus.mux_out;
            bus.out_ch    <= cur;
            bus.out_valid <= 1'b1;
            state         <= OUT;
          end
        end
        OUT: begin
          // Beat stays frozen until the consumer takes it.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            pend          <= rest;
            if (rest != '0) begin
              cur     <= lowest(rest);
              bus.sel <= lowest(rest);
              state   <= CAPTURE;
            end else begin
              bus.sel  <= '0;
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Testbench for scan_sequencer: vector table, directed corner sequences and randomized scans
// checked against a channel-list reference model.
module tb_scan_sequencer;
  localparam int NCH = 6;
  localparam int W   = 4;
  localparam int BUDGET = 300;

`ifdef SCAN_SEQ_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  typedef struct {
    logic [NCH-1:0] mask;
    int             exp_beats;
    int             exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] mux_data [8];

  int checks = 0;
  int failures = 0;

  logic [2:0]   sel_log[$];
  logic [2:0]   beat_ch_log[$];
  logic [W-1:0] beat_d_log[$];
  int           first_beat_cycles;

  scan_sequencer_if #(.NCH(NCH), .W(W)) bus ();

  scan_sequencer #(.NCH(NCH), .W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.mux_out = mux_data[bus.sel];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ramp_data();
    for (int i = 0; i < 8; i++) mux_data[i] = W'(i + 1);
  endtask

  // Reference: the beat list is the enabled channels in ascending order, minus zero samples
  // when skipping is built in; each beat costs 2 cycles plus stalls, each skip 1 cycle.
  task automatic run_scan(input logic [NCH-1:0] mask, input int ready_mode, input bit noisy,
                          output int nbeats, output int done_cyc);
    logic [2:0]   exp_ch[$];
    logic [W-1:0] exp_d[$];
    int  skipped, stalls, cyc, stall_left;
    bit  seen_done, prev_hold, rdy;
    skipped = 0; stalls = 0; nbeats = 0; done_cyc = 0;
    stall_left = 3; seen_done = 0; prev_hold = 0;
    first_beat_cycles = 0;
    sel_log.delete(); beat_ch_log.delete(); beat_d_log.delete();
    for (int i = 0; i < NCH; i++) begin
      if (mask[i]) begin
        if (ZS && mux_data[i] == '0) skipped++;
        else begin
          exp_ch.push_back(3'(i));
          exp_d.push_back(mux_data[i]);
        end
      end
    end
    bus.start = 1'b1;
    bus.ch_mask = mask;
    bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (!seen_done && cyc <= BUDGET) begin
      if (bus.done) begin
        seen_done = 1;
        done_cyc = cyc;
        check("done_sel", 32'(bus.sel), 0);
        check("done_valid", 32'(bus.out_valid), 0);
      end else begin
        sel_log.push_back(bus.sel);
        check("busy", 32'(bus.busy), 1);
        if (prev_hold) check("valid_held", 32'(bus.out_valid), 1);
        case (ready_mode)
          0: rdy = 1'b1;
          1: rdy = ($urandom_range(0, 3) != 0);
          default: begin
            if (bus.out_valid && stall_left > 0) begin
              rdy = 1'b0;
              stall_left--;
            end else rdy = 1'b1;
          end
        endcase
        bus.out_ready = rdy;
        if (bus.out_valid) begin
          if (nbeats == 0) first_beat_cycles++;
          check("beat_expected", 32'(exp_ch.size() != 0), 1);
          if (exp_ch.size() != 0) begin
            check("sel", 32'(bus.sel), 32'(exp_ch[0]));
            check("out_ch", 32'(bus.out_ch), 32'(exp_ch[0]));
            check("out_data", 32'(bus.out_data), 32'(exp_d[0]));
            if (noisy) mux_data[exp_ch[0]] = ~mux_data[exp_ch[0]];
            if (rdy) begin
              beat_ch_log.push_back(exp_ch.pop_front());
              beat_d_log.push_back(exp_d.pop_front());
              nbeats++;
            end else stalls++;
          end
        end
        prev_hold = bus.out_valid && !rdy;
        if (noisy) begin
          bus.start = 1'($urandom_range(0, 1));
          bus.ch_mask = NCH'($urandom);
        end
        tick();
        cyc++;
      end
    end
    bus.start = 1'b0;
    check("scan_finished", 32'(seen_done), 1);
    if (!seen_done) begin
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
    check("beats_left", 32'(exp_ch.size()), 0);
    check("done_cycle", 32'(done_cyc), 32'(1 + 2 * nbeats + skipped + stalls));
    tick();
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_done", 32'(bus.done), 0);
    check("idle_valid", 32'(bus.out_valid), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, 32'(bus.sel), 0);
    check({tag, "_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_ch"}, 32'(bus.out_ch), 0);
    check({tag, "_data"}, 32'(bus.out_data), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
  endtask

  initial begin
    vec_t vecs[6];
    int nb, dc, waited;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.ch_mask = '0;
    bus.out_ready = 1'b0;
    set_ramp_data();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    vecs[0] = '{6'b111111, 6, 13};
    vecs[1] = '{6'b100100, 2, 5};
    vecs[2] = '{6'b000000, 0, 1};
    vecs[3] = '{6'b000001, 1, 3};
    vecs[4] = '{6'b100000, 1, 3};
    vecs[5] = '{6'b010101, 3, 7};
    for (int v = 0; v < 6; v++) begin
      set_ramp_data();
      run_scan(vecs[v].mask, 0, 1'b0, nb, dc);
      check($sformatf("vec%0d_beats", v), 32'(nb), 32'(vecs[v].exp_beats));
      check($sformatf("vec%0d_done", v), 32'(dc), 32'(vecs[v].exp_done));
    end

    // Full scan: select walks each channel for its CAPTURE and OUT cycle.
    set_ramp_data();
    run_scan(6'b111111, 0, 1'b0, nb, dc);
    check("full_sel_len", 32'(sel_log.size()), 12);
    for (int i = 0; i < 12 && i < sel_log.size(); i++)
      check($sformatf("full_sel%0d", i), 32'(sel_log[i]), 32'(i / 2));

    // Sparse mask, first beat stalled three cycles.
    set_ramp_data();
    run_scan(6'b100100, 2, 1'b0, nb, dc);
    check("sparse_beats", 32'(nb), 2);
    check("sparse_hold_cycles", 32'(first_beat_cycles), 4);
    check("sparse_done", 32'(dc), 8);
    if (nb == 2) begin
      check("sparse_ch0", 32'(beat_ch_log[0]), 2);
      check("sparse_d0", 32'(beat_d_log[0]), 3);
      check("sparse_ch1", 32'(beat_ch_log[1]), 5);
      check("sparse_d1", 32'(beat_d_log[1]), 6);
    end

    // Start and mask toggled throughout a scan.
    set_ramp_data();
    run_scan(6'b010110, 0, 1'b1, nb, dc);
    check("noisy_beats", 32'(nb), 3);
    if (nb == 3) begin
      check("noisy_ch0", 32'(beat_ch_log[0]), 1);
      check("noisy_ch1", 32'(beat_ch_log[1]), 2);
      check("noisy_ch2", 32'(beat_ch_log[2]), 4);
    end

    // Reset while a beat is waiting.
    set_ramp_data();
    bus.ch_mask = 6'b111111;
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    waited = 0;
    while (!bus.out_valid && waited < 10) begin
      tick();
      waited++;
    end
    check("rst_pre_valid", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_no_done", 32'(bus.done), 0);
      check("rst_no_busy", 32'(bus.busy), 0);
      tick();
    end
    mux_data[0] = 4'h5;
    run_scan(6'b000001, 0, 1'b0, nb, dc);
    check("rst_beats", 32'(nb), 1);
    if (nb == 1) begin
      check("rst_beat_ch", 32'(beat_ch_log[0]), 0);
      check("rst_beat_d", 32'(beat_d_log[0]), 5);
    end

`ifdef SCAN_SEQ_ZERO_SKIP_EN
    set_ramp_data();
    mux_data[0] = 4'h0;
    mux_data[1] = 4'h3;
    mux_data[2] = 4'h0;
    run_scan(6'b000111, 0, 1'b0, nb, dc);
    check("zs_beats", 32'(nb), 1);
    check("zs_done", 32'(dc), 5);
    if (nb == 1) begin
      check("zs_ch", 32'(beat_ch_log[0]), 1);
      check("zs_d", 32'(beat_d_log[0]), 3);
    end
`endif

    // Randomized scans with random data, backpressure and mid-scan noise.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 8; i++)
        mux_data[i] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(0, 15));
      run_scan(NCH'($urandom), 1, 1'b1, nb, dc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

- Upstream control stage for the 6-input, 4-bit case-select mux.
- Walks the mux `sel` input through a software-supplied set of enabled channels and samples the mux output once per channel.
- Emits each sample as a `(channel, data)` beat on a valid/ready stream.
- Signals completion with a one-cycle `done` pulse, so a consumer can read all channels over one handshaked port.

## Interface
Parameters:
- `NCH`, 6: number of mux channels, 1..8; channels `NCH`..7 are never selected.
- `W`, 4: mux data width.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: begin a scan; sampled only in IDLE.
- `ch_mask`  in  NCH: enabled channels, bit i = channel i; latched on accepted `start`.
- `sel`  out  3: channel select driven to the mux.
- `mux_out`  in  W: mux output, combinational from `sel`.
- `out_valid`  out  1: sample beat valid.
- `out_ready`  in  1: consumer accepts beat.
- `out_ch`  out  3: channel of current beat.
- `out_data`  out  W: sampled data of current beat.
- `busy`  out  1: scan in progress (state != IDLE).
- `done`  out  1: one-cycle pulse at end of scan.

## Operation
- States: IDLE, CAPTURE, OUT, DONE. Registered `pend[NCH-1:0]`, `cur[2:0]`, `out_data`.
- IDLE:
  - `start`=1 latches `pend <= ch_mask` and `cur <=` lowest set bit.
  - Goes to CAPTURE if `ch_mask` != 0, else to DONE.
  - `start`=0 stays in IDLE.
- CAPTURE:
  - `sel = cur`; `out_data <= mux_out` at the clock edge.
  - Goes to OUT.
- OUT:
  - `out_valid`=1, `out_ch = cur`. `out_data` and `out_ch` are stable until the handshake.
  - On `out_valid & out_ready`: clear `pend[cur]`.
  - If bits remain: `cur <=` next-lowest remaining bit, go to CAPTURE. Otherwise go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Channels are always served in ascending index order.
- `start` is ignored while `busy`=1. `ch_mask` changes mid-scan have no effect.
- `sel` is held at 0 in IDLE and DONE, and equals `cur` in CAPTURE and OUT.
- `out_valid` never drops without a handshake.
- Reset (any state, asynchronous):
  - State = IDLE; `sel`=0, `out_valid`=0, `out_ch`=0, `out_data`=0, `busy`=0, `done`=0, `pend`=0.
  - A beat pending at reset is lost; no `done` is issued.

## Timing
- `start` accepted at edge k: CAPTURE during cycle k+1, `out_valid`=1 from cycle k+2.
- Each channel costs 2 cycles (CAPTURE + OUT) when `out_ready` is held high. Each stalled cycle in OUT adds one cycle.
- N enabled channels with continuous ready: `done` is asserted in cycle k+2N+1 and `busy` falls in cycle k+2N+2.
- Empty mask: `done` in cycle k+1, no beats.
- `mux_out` is sampled only at the CAPTURE edge. Later changes do not affect the beat.
- The next `start` is accepted in IDLE, no earlier than the cycle after `done`.

## Configuration
- `SCAN_SEQ_ZERO_SKIP_EN` defined:
  - In CAPTURE, if `mux_out` == 0, no beat is issued. `pend[cur]` is cleared and the FSM advances directly to the next CAPTURE, or to DONE if none remain. Such a channel costs 1 cycle.
  - A scan in which every channel samples zero produces no beats but still pulses `done`.
- Undefined: every enabled channel produces a beat, including zero values.

## Test plan
- Reset mid-OUT:
  - Stimulus: `rst_n` low while `out_valid`=1.
  - Response: all outputs 0 immediately; after release, `start` with `ch_mask`=6'b000001 and `mux_out`=4'h5 gives one beat {0, 4'h5}.
- Full scan with `out_ready`=1, `ch_mask`=6'b111111, mux returning data i+1:
  - Beats ch0..5 carry data 1..6.
  - `done` arrives 13 cycles after `start`.
  - `sel` sequence: 0,0,1,1,2,2,3,3,4,4,5,5.
- Sparse mask 6'b100100 with `out_ready` low for 3 cycles on the first beat:
  - Beat {2, d2} is held stable for 4 cycles, then beat {5, d5} follows.
  - `done` follows the second handshake.
- Empty mask:
  - Stimulus: `start` with `ch_mask`=0.
  - Response: `done` one cycle later, `out_valid` never rises.
- `start` pulsed during a scan, with `ch_mask` changed mid-scan:
  - Response: ignored; beat set and order follow the original mask.
- `SCAN_SEQ_ZERO_SKIP_EN` defined, mask 6'b000111, data {0, 4'h3, 0}:
  - Response: single beat {1, 4'h3}, then `done`.
